// File: rtl/rv_lsu_core.sv
// Load/store unit: one memory op at a time over a req/gnt/rvalid bus with lane steering and load extension.
// Optional LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two bus beats.
module rv_lsu_core #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_err,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [4:0]          rsp_rd,
  output logic                rsp_err,
  output logic                rsp_misaligned
);
  // state  | meaning
  // IDLE   | ready for a new operation
  // REQ    | bus request held until granted (beat 1 or 2)
  // WAIT   | granted, waiting for the response beat
  // RESP   | one-cycle completion pulse

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic                op_write, op_unsigned, op_beat2;
  logic [1:0]          op_size;
  logic [ADDR_W-1:0]   op_addr;
  logic [XLEN-1:0]     op_wdata, rdata_lo, rsp_data_q;
  logic [4:0]          op_rd;
  logic                rsp_err_q, rsp_mis_q;

  logic [OFF_W-1:0]    in_off, op_off;
  logic [2*NB-1:0]     in_be, op_be;
  logic                in_cross, in_illegal, in_reject, op_cross, split_pending;
  logic [2*XLEN-1:0]   wd_full, rd_comb;
  logic [ADDR_W-1:0]   addr_base;

  // Enables over two consecutive bus words; the upper half is the overflow lanes.
  function automatic logic [2*NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return (2*NB)'(m) << off;
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] data, input logic [1:0] size,
                                             input logic [OFF_W-1:0] off, input logic uns);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   mask, ext;
    int                nbits;
    sh    = data >> {off, 3'b000};
    nbits = 8 << size;
    mask  = (nbits >= XLEN) ? '1 : ~({XLEN{1'b1}} << nbits);
    ext   = (!uns && sh[nbits-1]) ? ~mask : '0;
    return (sh[XLEN-1:0] & mask) | ext;
  endfunction

  assign in_off        = req_addr[OFF_W-1:0];
  assign in_be         = lane_mask(req_size, in_off);
  assign in_cross      = |in_be[2*NB-1:NB];
  assign in_illegal    = (XLEN == 32) && (req_size == 2'b11);
  assign in_reject     = in_illegal || (in_cross && !SPLIT_EN);

  assign op_off        = op_addr[OFF_W-1:0];
  assign op_be         = lane_mask(op_size, op_off);
  assign op_cross      = |op_be[2*NB-1:NB];
  assign split_pending = SPLIT_EN && op_cross && !op_beat2;
  assign wd_full       = (2*XLEN)'(op_wdata) << {op_off, 3'b000};
  assign addr_base     = {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign rd_comb       = op_beat2 ? {mem_rdata, rdata_lo} : {{XLEN{1'b0}}, mem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = in_reject ? S_RESP : S_REQ;
      S_REQ:  if (mem_gnt) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = (!mem_err && split_pending) ? S_REQ : S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state == S_IDLE);
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_be         = '0;
    mem_wdata      = '0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_rd         = '0;
    rsp_err        = 1'b0;
    rsp_misaligned = 1'b0;
    case (state)
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = op_write;
        mem_addr  = op_beat2 ? addr_base + ADDR_W'(NB) : addr_base;
        mem_be    = op_beat2 ? op_be[2*NB-1:NB] : op_be[NB-1:0];
        mem_wdata = op_beat2 ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];
      end
      S_RESP: begin
        rsp_valid      = 1'b1;
        rsp_rdata      = rsp_data_q;
        rsp_rd         = op_rd;
        rsp_err        = rsp_err_q;
        rsp_misaligned = rsp_mis_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write    <= 1'b0;
      op_unsigned <= 1'b0;
      op_beat2    <= 1'b0;
      op_size     <= '0;
      op_addr     <= '0;
      op_wdata    <= '0;
      op_rd       <= '0;
      rdata_lo    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      op_write    <= req_write;
      op_unsigned <= req_unsigned;
      op_beat2    <= 1'b0;
      op_size     <= req_size;
      op_addr     <= req_addr;
      op_wdata    <= req_wdata;
      op_rd       <= req_rd;
      rsp_data_q  <= '0;
      rsp_err_q   <= in_illegal;
      rsp_mis_q   <= !in_illegal && in_reject;
    end else if (state == S_WAIT && mem_rvalid) begin
      if (mem_err) begin
        rsp_err_q  <= 1'b1;
        rsp_data_q <= '0;
      end else if (split_pending) begin
        rdata_lo <= mem_rdata;
        op_beat2 <= 1'b1;
      end else begin
        rsp_data_q <= op_write ? '0 : extract(rd_comb, op_size, op_off, op_unsigned);
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu_core.sv
// Directed bench for rv_lsu_core: a 32-bit instance for most cases and a 64-bit instance for double-word access.
module tb_rv_lsu_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err, rsp_misaligned;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  logic        d_req_valid, d_req_ready, d_req_write, d_req_unsigned;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [4:0]  d_req_rd;
  logic        d_mem_req, d_mem_gnt, d_mem_we, d_mem_rvalid, d_mem_err;
  logic [31:0] d_mem_addr;
  logic [63:0] d_mem_wdata, d_mem_rdata;
  logic [7:0]  d_mem_be;
  logic        d_rsp_valid, d_rsp_err, d_rsp_misaligned;
  logic [63:0] d_rsp_rdata;
  logic [4:0]  d_rsp_rd;

  rv_lsu_core #(.XLEN(32), .ADDR_W(32)) u_lsu32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .rsp_misaligned(rsp_misaligned)
  );

  rv_lsu_core #(.XLEN(64), .ADDR_W(32)) u_lsu64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_write(d_req_write), .req_size(d_req_size),
    .req_unsigned(d_req_unsigned), .req_addr(d_req_addr), .req_wdata(d_req_wdata), .req_rd(d_req_rd),
    .mem_req(d_mem_req), .mem_gnt(d_mem_gnt), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_be(d_mem_be),
    .mem_wdata(d_mem_wdata), .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata), .mem_err(d_mem_err),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata), .rsp_rd(d_rsp_rd), .rsp_err(d_rsp_err),
    .rsp_misaligned(d_rsp_misaligned)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one op for the accept edge; t0 marks cycle 1 after acceptance.
  task automatic issue32(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, output int t0);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; req_rd = rd;
    tick;
    req_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic beat32(input int stall, input logic [31:0] rdata, input logic err,
                        output logic [31:0] a, output logic [3:0] be, output logic [31:0] wd, output logic we);
    for (int i = 0; i < 8 && !mem_req; i++) tick;
    check("beat_req", {63'd0, mem_req}, 64'd1);
    a = mem_addr; be = mem_be; wd = mem_wdata; we = mem_we;
    repeat (stall) tick;
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    tick;
    mem_rvalid = 1'b0; mem_err = 1'b0;
  endtask

  task automatic wait_rsp32(input int t0, output int lat);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick;
    check("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    lat = cyc - t0 + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, lat;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;

    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    d_req_valid = 0; d_req_write = 0; d_req_size = 0; d_req_unsigned = 0; d_req_addr = 0; d_req_wdata = 0; d_req_rd = 0;
    d_mem_gnt = 0; d_mem_rvalid = 0; d_mem_rdata = 0; d_mem_err = 0;
    #12;
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_bus", {mem_addr, 4'd0, mem_be, 23'd0, mem_we}, 64'd0);
    check("rst_rsp", {rsp_rdata, 25'd0, rsp_rd, rsp_err, rsp_misaligned}, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // stray response in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick;
    mem_rvalid = 1'b0;
    check("stray_rvalid", {62'd0, rsp_valid, req_ready}, 64'd1);

    // LB / LBU at byte 3
    issue32(0, 2'b00, 0, 32'h1003, 0, 5'd9, t0);
    beat32(0, 32'h8012_3456, 0, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("lb_addr", a, 32'h1000);
    check("lb_be", be, 4'b1000);
    check("lb_data", rsp_rdata, 32'hFFFF_FF80);
    check("lb_rd", rsp_rd, 5'd9);
    tick;
    issue32(0, 2'b00, 1, 32'h1003, 0, 5'd10, t0);
    beat32(0, 32'h8012_3456, 0, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("lbu_data", rsp_rdata, 32'h0000_0080);
    tick;

    // SH with immediate grant: minimum latency
    issue32(1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 5'd3, t0);
    beat32(0, 32'h0, 0, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("sh_we", {63'd0, we}, 64'd1);
    check("sh_be", be, 4'b1100);
    check("sh_wdata", wd, 32'hBEEF_0000);
    check("sh_latency", lat, 3);
    check("sh_rdata", rsp_rdata, 32'h0);
    tick;
    check("sh_ready_after", {63'd0, req_ready}, 64'd1);

    // misaligned but non-crossing LH at offset 1
    issue32(0, 2'b01, 0, 32'h1001, 0, 5'd4, t0);
    beat32(0, 32'h8012_3456, 0, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("lh_off1_be", be, 4'b0110);
    check("lh_off1_data", rsp_rdata, 32'h0000_1234);
    check("lh_off1_mis", {63'd0, rsp_misaligned}, 64'd0);
    tick;

    // word crossing a bus-word boundary
`ifdef LSU_MISALIGNED_SPLIT_EN
    issue32(0, 2'b10, 0, 32'h3002, 0, 5'd7, t0);
    beat32(0, 32'hAABB_CCDD, 0, a, be, wd, we);
    check("split_b1_addr", a, 32'h3000);
    check("split_b1_be", be, 4'b1100);
    beat32(0, 32'h1122_3344, 0, a, be, wd, we);
    check("split_b2_addr", a, 32'h3004);
    check("split_b2_be", be, 4'b0011);
    wait_rsp32(t0, lat);
    check("split_data", rsp_rdata, 32'h3344_AABB);
    check("split_latency", lat, 5);
    tick;
`else
    issue32(0, 2'b10, 0, 32'h3002, 0, 5'd7, t0);
    check("mis_cycle1", {62'd0, rsp_valid, rsp_misaligned}, 64'd3);
    check("mis_err", {63'd0, rsp_err}, 64'd0);
    check("mis_no_req", {63'd0, mem_req}, 64'd0);
    tick;
    check("mis_no_req_after", {62'd0, mem_req, req_ready}, 64'd1);
`endif

    // bus fault
    issue32(0, 2'b10, 0, 32'h6000, 0, 5'd11, t0);
    beat32(0, 32'h1234_5678, 1, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("fault_err", {63'd0, rsp_err}, 64'd1);
    check("fault_data", rsp_rdata, 32'h0);
    tick;

    // illegal double at XLEN=32
    issue32(0, 2'b11, 0, 32'h7000, 0, 5'd12, t0);
    check("illegal_cycle1", {61'd0, rsp_valid, rsp_err, rsp_misaligned}, 64'b110);
    check("illegal_no_req", {63'd0, mem_req}, 64'd0);
    tick;

    // reset during WAIT, then a late response
    issue32(0, 2'b10, 0, 32'h5000, 0, 5'd13, t0);
    check("rst_op_req", {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_drop", {62'd0, mem_req, req_ready}, 64'd1);
    tick;
    rst_n = 1'b1;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= rsp_valid;
      tick;
      mem_rvalid = 1'b0;
    end
    check("rst_no_rsp", {63'd0, seen}, 64'd0);
    check("rst_ready_after", {63'd0, req_ready}, 64'd1);
    issue32(0, 2'b10, 0, 32'h5004, 0, 5'd14, t0);
    beat32(0, 32'hCAFE_F00D, 0, a, be, wd, we);
    wait_rsp32(t0, lat);
    check("post_rst_addr", a, 32'h5004);
    check("post_rst_data", rsp_rdata, 32'hCAFE_F00D);
    tick;

    // XLEN=64: LD with five stalled grant cycles
    d_req_valid = 1'b1; d_req_size = 2'b11; d_req_addr = 32'h4000; d_req_rd = 5'd20;
    tick;
    d_req_valid = 1'b0;
    check("ld_req", {63'd0, d_mem_req}, 64'd1);
    check("ld_addr", d_mem_addr, 32'h4000);
    check("ld_be", d_mem_be, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("ld_req_hold", {63'd0, d_mem_req}, 64'd1);
      check("ld_addr_hold", d_mem_addr, 32'h4000);
    end
    d_mem_gnt = 1'b1;
    tick;
    d_mem_gnt = 1'b0;
    d_mem_rvalid = 1'b1; d_mem_rdata = 64'h8123_4567_89AB_CDEF;
    tick;
    d_mem_rvalid = 1'b0;
    check("ld_valid", {63'd0, d_rsp_valid}, 64'd1);
    check("ld_data", d_rsp_rdata, 64'h8123_4567_89AB_CDEF);
    check("ld_rd", d_rsp_rd, 5'd20);
    tick;

    // XLEN=64: signed LW in the upper half sign-extends to 64 bits
    d_req_valid = 1'b1; d_req_size = 2'b10; d_req_unsigned = 1'b0; d_req_addr = 32'h4004; d_req_rd = 5'd21;
    tick;
    d_req_valid = 1'b0;
    check("lw64_be", d_mem_be, 8'hF0);
    d_mem_gnt = 1'b1;
    tick;
    d_mem_gnt = 1'b0;
    d_mem_rvalid = 1'b1; d_mem_rdata = 64'hDEAD_BEEF_0000_0000;
    tick;
    d_mem_rvalid = 1'b0;
    check("lw64_data", d_rsp_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
